// File: rtl/prog_run_ctrl.sv
// rtl/prog_run_ctrl.sv - run-control sequencer: START/DONE handshake, core reset/PC load, halt detect, watchdog
module prog_run_ctrl #(
    parameter int                 PC_W        = 8,
    parameter int                 NUM_PROGS   = 3,
    parameter logic [PC_W-1:0]    START_ADDR0 = '0,
    parameter logic [PC_W-1:0]    START_ADDR1 = '0,
    parameter logic [PC_W-1:0]    START_ADDR2 = '0,
    parameter logic [PC_W-1:0]    START_ADDR3 = '0,
    parameter int                 CNT_W       = 16,
    parameter logic [CNT_W-1:0]   MAX_CYCLES  = 16'hFFFF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic              HALT,
    output logic              DONE,
    output logic              CORE_RST,
    output logic              RUN,
    output logic              PC_LOAD,
    output logic [PC_W-1:0]   PC_INIT,
    output logic [1:0]        PROG_ID,
    output logic [CNT_W-1:0]  CYCLES,
    output logic              TIMEOUT
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_RUN    = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              start_q;
    logic              start_edge;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_inc;
    logic              wd_hit;
    logic              run_end;
    logic [1:0]        prog_next;

    assign start_edge = START && !start_q;
    // Counter saturates so a huge MAX_CYCLES never wraps back to a small count.
    assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    assign wd_hit     = (cnt_inc == MAX_CYCLES);
    assign run_end    = HALT || wd_hit;
    assign prog_next  = (PROG_ID == 2'(NUM_PROGS - 1)) ? 2'd0 : PROG_ID + 2'd1;

    always_comb begin
        state_d  = state_q;
        CORE_RST = 1'b0;
        RUN      = 1'b0;
        PC_LOAD  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                CORE_RST = 1'b1;
                if (start_edge) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                CORE_RST = 1'b1;
                PC_LOAD  = 1'b1;
                state_d  = ST_RUN;
            end
            ST_RUN: begin
                RUN = 1'b1;
                if (run_end) state_d = ST_FINISH;
            end
            ST_FINISH: begin
                if (start_edge) state_d = ST_LOAD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        case (PROG_ID)
            2'd0:    PC_INIT = START_ADDR0;
            2'd1:    PC_INIT = START_ADDR1;
            2'd2:    PC_INIT = START_ADDR2;
            default: PC_INIT = START_ADDR3;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            start_q <= 1'b0;
            cnt_q   <= '0;
            DONE    <= 1'b0;
            PROG_ID <= 2'd0;
            CYCLES  <= '0;
            TIMEOUT <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= START;
            case (state_q)
                ST_IDLE, ST_FINISH: begin
                    if (start_edge) DONE <= 1'b0;
                end
                ST_LOAD: cnt_q <= '0;
                ST_RUN: begin
                    cnt_q <= cnt_inc;
                    // HALT takes priority over the watchdog when both land together.
                    if (run_end) begin
                        DONE    <= 1'b1;
                        CYCLES  <= HALT ? cnt_inc : MAX_CYCLES;
                        TIMEOUT <= !HALT;
                        PROG_ID <= prog_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_run_ctrl.sv
// tb/tb_prog_run_ctrl.sv - self-checking bench for prog_run_ctrl
module tb_prog_run_ctrl;

    localparam int MAXC  = 20;
    localparam int NUMP  = 3;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        START = 1'b0;
    logic        HALT = 1'b0;
    logic        DONE, CORE_RST, RUN, PC_LOAD, TIMEOUT;
    logic [7:0]  PC_INIT;
    logic [1:0]  PROG_ID;
    logic [15:0] CYCLES;

    prog_run_ctrl #(
        .PC_W(8), .NUM_PROGS(NUMP),
        .START_ADDR0(8'h00), .START_ADDR1(8'h40), .START_ADDR2(8'h80), .START_ADDR3(8'hC0),
        .CNT_W(16), .MAX_CYCLES(16'd20)
    ) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .HALT(HALT),
        .DONE(DONE), .CORE_RST(CORE_RST), .RUN(RUN), .PC_LOAD(PC_LOAD),
        .PC_INIT(PC_INIT), .PROG_ID(PROG_ID), .CYCLES(CYCLES), .TIMEOUT(TIMEOUT)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", nm, got, exp);
        end
    endtask

    // Model: a run is "busy" from the accepted START edge; age 0 is the load
    // cycle and age n>=1 is the n-th run cycle.
    logic [7:0] addr_tab [4] = '{8'h00, 8'h40, 8'h80, 8'hC0};
    bit m_valid = 0, m_busy = 0, m_done = 0, m_tmo = 0, m_prev = 0;
    int m_age = 0, m_cyc = 0, m_prog = 0;

    task automatic m_finish(input int c, input bit t);
        m_busy = 0; m_done = 1; m_cyc = c; m_tmo = t;
        m_prog = (m_prog + 1) % NUMP;
    endtask

    always @(posedge CLK) begin
        bit acc;
        if (RESET) begin
            m_valid = 1; m_busy = 0; m_age = 0; m_done = 0;
            m_cyc = 0; m_tmo = 0; m_prog = 0; m_prev = 0;
        end else if (m_valid) begin
            acc = START && !m_prev;
            m_prev = START;
            if (m_busy) begin
                if (m_age == 0)          m_age = 1;
                else if (HALT)           m_finish(m_age, 0);
                else if (m_age == MAXC)  m_finish(MAXC, 1);
                else                     m_age++;
            end else if (acc) begin
                m_busy = 1; m_age = 0; m_done = 0;
            end
        end
    end

    always @(negedge CLK) begin
        if (m_valid) begin
            chk("done",     DONE,     m_done);
            chk("core_rst", CORE_RST, (m_busy && m_age == 0) || (!m_busy && !m_done));
            chk("run",      RUN,      m_busy && m_age >= 1);
            chk("pc_load",  PC_LOAD,  m_busy && m_age == 0);
            chk("pc_init",  PC_INIT,  addr_tab[m_prog]);
            chk("prog_id",  PROG_ID,  m_prog);
            chk("cycles",   CYCLES,   m_cyc);
            chk("timeout",  TIMEOUT,  m_tmo);
        end
    end

    // Independent capture of load strobes and run lengths for literal checks.
    int load_count = 0;
    int run_len = 0;
    logic [7:0] pcq [$];
    always @(negedge CLK) begin
        if (PC_LOAD === 1'b1) begin
            load_count++;
            pcq.push_back(PC_INIT);
            run_len = 0;
        end
        if (RUN === 1'b1) run_len++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic start_run();
        START = 1'b1;
        tick(1);
        chk("done_clr_on_start", DONE, 0);
        START = 1'b0;
        tick(1);
    endtask

    task automatic run_prog(input int halt_at);
        start_run();
        if (halt_at > 0) begin
            tick(halt_at - 1);
            HALT = 1'b1;
            tick(1);
            HALT = 1'b0;
        end else begin
            for (int i = 0; i < 100 && DONE !== 1'b1; i++) tick(1);
        end
        chk("done_after_run", DONE, 1);
    endtask

    int lc0;
    logic [1:0] pid_seq [4];
    logic [7:0] pc_exp [4] = '{8'h00, 8'h40, 8'h80, 8'h00};
    logic [1:0] pid_exp [4] = '{2'd1, 2'd2, 2'd0, 2'd1};

    initial begin
        tick(2);
        RESET = 1'b0;
        chk("rst_done", DONE, 0);
        chk("rst_core_rst", CORE_RST, 1);
        chk("rst_cycles", CYCLES, 0);

        HALT = 1'b1;
        tick(2);
        HALT = 1'b0;
        chk("idle_halt_core_rst", CORE_RST, 1);
        chk("idle_halt_run", RUN, 0);

        run_prog(5);
        chk("t1_cycles", CYCLES, 5);
        chk("t1_timeout", TIMEOUT, 0);
        chk("t1_run_len", run_len, 5);
        pid_seq[0] = PROG_ID;
        for (int r = 1; r < 4; r++) begin
            run_prog(2);
            pid_seq[r] = PROG_ID;
        end
        chk("t2_loads", load_count, 4);
        for (int r = 0; r < 4; r++) begin
            chk("t2_pc_init", pcq[r], pc_exp[r]);
            chk("t2_prog_id", pid_seq[r], pid_exp[r]);
        end

        run_prog(0);
        chk("t3_timeout", TIMEOUT, 1);
        chk("t3_cycles", CYCLES, 20);
        chk("t3_run_len", run_len, 20);
        run_prog(3);
        chk("t3b_timeout", TIMEOUT, 0);
        chk("t3b_cycles", CYCLES, 3);

        run_prog(20);
        chk("t4_timeout", TIMEOUT, 0);
        chk("t4_cycles", CYCLES, 20);

        lc0 = load_count;
        START = 1'b1;
        tick(3);
        START = 1'b0;
        tick(2);
        START = 1'b1;
        tick(1);
        START = 1'b0;
        tick(1);
        HALT = 1'b1;
        tick(1);
        HALT = 1'b0;
        chk("t5_one_load", load_count - lc0, 1);
        chk("t5_cycles", CYCLES, 6);
        HALT = 1'b1;
        tick(2);
        HALT = 1'b0;
        chk("t5_finish_halt_done", DONE, 1);
        chk("t5_finish_halt_loads", load_count - lc0, 1);

        start_run();
        tick(6);
        chk("t6_in_run", RUN, 1);
        RESET = 1'b1;
        tick(1);
        chk("t6_run", RUN, 0);
        chk("t6_core_rst", CORE_RST, 1);
        chk("t6_done", DONE, 0);
        chk("t6_prog_id", PROG_ID, 0);
        chk("t6_cycles", CYCLES, 0);
        RESET = 1'b0;
        lc0 = load_count;
        run_prog(2);
        chk("t6_fresh_pc", pcq[lc0], 8'h00);
        chk("t6_fresh_prog_id", PROG_ID, 1);

        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
